// File: rtl/wb_sram_ctrl_if.sv
// rtl/wb_sram_ctrl_if.sv - Wishbone classic bus bundle for wb_sram_ctrl
interface wb_sram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic                    wb_we_i;
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic [2:0]              wb_cti_i;
    logic [1:0]              wb_bte_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_ack_o;
    logic                    wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone classic slave around an inferred single-port RAM
// Linear incrementing read bursts are compiled in with WB_SRAM_CTRL_BURST_EN.
module wb_sram_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int WORDS        = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input logic           wb_clk_i,
    input logic           wb_rst_ni,
    wb_sram_ctrl_if.slave bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PD  = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [ADDR_WIDTH-1:0] W_LIM = ADDR_WIDTH'(WORDS);

`ifdef WB_SRAM_CTRL_BURST_EN
    typedef enum logic [1:0] {IDLE, RWAIT, BURST} state_t;
`else
    typedef enum logic [1:0] {IDLE, RWAIT} state_t;
`endif

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    state_t                r_state;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_pd [PD];
    logic [PD-1:0]         r_pv;
    logic [PD-1:0]         r_pe;

    logic                  w_req, w_oor, w_wr_en, w_start, w_issue, w_shift;
    logic                  w_rd_oor, w_fin_v, w_fin_e;
    logic [ADDR_WIDTH-1:0] w_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0] w_ram_q, w_fin_d;

    // Holding off while a termination is visible keeps a master that leaves stb high from double-issuing.
    assign w_req   = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack & ~r_err;
    assign w_idx   = bus.wb_adr_i >> LSB;
    assign w_oor   = (w_idx >= W_LIM);
    assign w_wr_en = (r_state == IDLE) & w_req & ~w_oor & bus.wb_we_i;
    assign w_start = (r_state == IDLE) & w_req & ~w_oor & ~bus.wb_we_i;

`ifdef WB_SRAM_CTRL_BURST_EN
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_burst_req, w_last, w_adv, w_end;

    // Write bursts complete beat by beat as classic cycles; only reads stream.
    assign w_burst_req = (bus.wb_cti_i == 3'b010) & (bus.wb_bte_i == 2'b00);
    assign w_last      = (bus.wb_cti_i == 3'b111);
    assign w_adv       = (r_state == BURST) & bus.wb_cyc_i & bus.wb_stb_i & ~(w_last & r_ack);
    assign w_end       = (r_state == BURST) & bus.wb_cyc_i & bus.wb_stb_i & w_last & r_ack;
    assign w_issue     = w_start | w_adv;
    assign w_shift     = (r_state != BURST) | w_adv;
    assign w_rd_idx    = (r_state == BURST) ? r_addr : w_idx;
    assign w_rd_oor    = (r_state == BURST) & (r_addr >= W_LIM);
`else
    assign w_issue  = w_start;
    assign w_shift  = 1'b1;
    assign w_rd_idx = w_idx;
    assign w_rd_oor = 1'b0;
`endif

    assign w_ram_q = r_mem[w_rd_idx[IW-1:0]];
    // With a single-stage read the RAM output feeds the response register directly.
    assign w_fin_v = (READ_LATENCY == 1) ? w_issue  : (r_pv[PD-1] & w_shift & bus.wb_cyc_i);
    assign w_fin_e = (READ_LATENCY == 1) ? w_rd_oor : r_pe[PD-1];
    assign w_fin_d = (READ_LATENCY == 1) ? w_ram_q  : r_pd[PD-1];

    always_ff @(posedge wb_clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wb_sel_i[b]) r_mem[w_idx[IW-1:0]][b*8 +: 8] <= bus.wb_dat_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_pv    <= '0;
            r_pe    <= '0;
            for (int k = 0; k < PD; k++) r_pd[k] <= '0;
`ifdef WB_SRAM_CTRL_BURST_EN
            r_addr  <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_shift) begin
                for (int k = PD - 1; k > 0; k--) begin
                    r_pv[k] <= r_pv[k-1];
                    r_pe[k] <= r_pe[k-1];
                    r_pd[k] <= r_pd[k-1];
                end
                r_pv[0] <= w_issue & (READ_LATENCY > 1);
                r_pe[0] <= w_rd_oor;
                r_pd[0] <= w_ram_q;
            end
            if (w_fin_v) begin
                if (w_fin_e) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    r_dat <= w_fin_d;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_oor)               r_err   <= 1'b1;
                        else if (bus.wb_we_i)    r_ack   <= 1'b1;
`ifdef WB_SRAM_CTRL_BURST_EN
                        else if (w_burst_req) begin
                            r_state <= BURST;
                            r_addr  <= w_idx + ADDR_WIDTH'(1);
                        end
`endif
                        else if (READ_LATENCY > 1) r_state <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (!bus.wb_cyc_i) begin
                        r_state <= IDLE;
                        r_pv    <= '0;
                    end else if (w_fin_v) begin
                        r_state <= IDLE;
                    end
                end
`ifdef WB_SRAM_CTRL_BURST_EN
                BURST: begin
                    if (w_adv) r_addr <= r_addr + ADDR_WIDTH'(1);
                    if (!bus.wb_cyc_i || w_end || (w_fin_v && w_fin_e)) begin
                        r_state <= IDLE;
                        r_pv    <= '0;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wb_dat_o = r_dat;
    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb/tb_wb_sram_ctrl.sv - self-checking bench for wb_sram_ctrl against a word-array model
module tb_wb_sram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_sram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();
    wb_sram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();

    wb_sram_ctrl #(.DATA_WIDTH(32), .WORDS(200), .ADDR_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if1));
    wb_sram_ctrl #(.DATA_WIDTH(32), .WORDS(200), .ADDR_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if3));
`ifdef WB_SRAM_CTRL_BURST_EN
    wb_sram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if2 ();
    wb_sram_ctrl #(.DATA_WIDTH(32), .WORDS(200), .ADDR_WIDTH(32), .READ_LATENCY(2)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if2));
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mm [1:3][200];
    logic [31:0] last [1:3];
    int lat [1:3];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(int w, logic cyc, logic stb, logic we, logic [31:0] adr,
                           logic [31:0] dat, logic [3:0] sel, logic [2:0] cti);
        case (w)
            1: begin
                if1.wb_cyc_i = cyc; if1.wb_stb_i = stb; if1.wb_we_i = we; if1.wb_adr_i = adr;
                if1.wb_dat_i = dat; if1.wb_sel_i = sel; if1.wb_cti_i = cti; if1.wb_bte_i = 2'b00;
            end
            3: begin
                if3.wb_cyc_i = cyc; if3.wb_stb_i = stb; if3.wb_we_i = we; if3.wb_adr_i = adr;
                if3.wb_dat_i = dat; if3.wb_sel_i = sel; if3.wb_cti_i = cti; if3.wb_bte_i = 2'b00;
            end
`ifdef WB_SRAM_CTRL_BURST_EN
            2: begin
                if2.wb_cyc_i = cyc; if2.wb_stb_i = stb; if2.wb_we_i = we; if2.wb_adr_i = adr;
                if2.wb_dat_i = dat; if2.wb_sel_i = sel; if2.wb_cti_i = cti; if2.wb_bte_i = 2'b00;
            end
`endif
            default: ;
        endcase
    endtask

    function automatic logic get_ack(int w);
        case (w)
            1: return if1.wb_ack_o;
            3: return if3.wb_ack_o;
`ifdef WB_SRAM_CTRL_BURST_EN
            2: return if2.wb_ack_o;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic get_err(int w);
        case (w)
            1: return if1.wb_err_o;
            3: return if3.wb_err_o;
`ifdef WB_SRAM_CTRL_BURST_EN
            2: return if2.wb_err_o;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] get_dat(int w);
        case (w)
            1: return if1.wb_dat_o;
            3: return if3.wb_dat_o;
`ifdef WB_SRAM_CTRL_BURST_EN
            2: return if2.wb_dat_o;
`endif
            default: return '0;
        endcase
    endfunction

    // One classic access; response kind, latency and data come from the word-array model.
    task automatic access(int w, logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                          string tag);
        logic [31:0] idx;
        logic        oor, a, e;
        int          n, exp_n;
        idx   = adr >> 2;
        oor   = (idx >= 32'd200);
        exp_n = (oor || we) ? 1 : lat[w];
        @(posedge clk); #1;
        set_bus(w, 1'b1, 1'b1, we, adr, dat, sel, 3'b000);
        n = 0; a = 1'b0; e = 1'b0;
        while (!(a || e) && n < 10) begin
            @(posedge clk); #1;
            n++;
            a = get_ack(w);
            e = get_err(w);
            chk({tag, "_excl"}, {62'd0, a, e} == 64'd3, 64'd0);
        end
        set_bus(w, 1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000);
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_err"}, e, oor);
        if (!oor && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) mm[w][idx][8*b +: 8] = dat[8*b +: 8];
        end else if (!oor) begin
            last[w] = mm[w][idx];
        end
        chk({tag, "_dat"}, get_dat(w), last[w]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p, r;
        logic [31:0] adr;
        set_bus(1, 0, 0, 0, '0, '0, '0, 3'b000);
        set_bus(3, 0, 0, 0, '0, '0, '0, 3'b000);
        set_bus(2, 0, 0, 0, '0, '0, '0, 3'b000);
        lat[1] = 1; lat[2] = 2; lat[3] = 3;
        for (int w = 1; w <= 3; w++) last[w] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack1", get_ack(1), 0);
        chk("rst_err1", get_err(1), 0);
        chk("rst_dat1", get_dat(1), 0);
        chk("rst_ack3", get_ack(3), 0);
        chk("rst_dat3", get_dat(3), 0);
        rst_n = 1'b1;

        access(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full");
        access(1, 0, 32'h10, 32'h0, 4'hF, "rd_full");
        chk("rd_deadbeef", get_dat(1), 32'hDEADBEEF);
        access(1, 1, 32'h10, 32'h0000AB00, 4'b0010, "wr_lane1");
        access(1, 0, 32'h10, 32'h0, 4'hF, "rd_lane1");
        chk("rd_deadabef", get_dat(1), 32'hDEADABEF);
        access(1, 1, 32'h10, 32'hFFFFFFFF, 4'h0, "wr_nosel");
        access(1, 0, 32'h10, 32'h0, 4'hF, "rd_nosel");
        access(1, 0, 32'h320, 32'h0, 4'hF, "rd_oor200");
        chk("oor_dat_hold", get_dat(1), 32'hDEADABEF);
        access(1, 1, 32'h8000_0010, 32'h5555_5555, 4'hF, "wr_hibits");
        access(1, 0, 32'h10, 32'h0, 4'hF, "rd_after_hibits");

        // stb held high: the ack cycle is not a request, so acks alternate
        @(posedge clk); #1;
        set_bus(1, 1, 1, 1, 32'h20, 32'h1234_5678, 4'hF, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("b2b_ack", get_ack(1), k % 2);
        end
        set_bus(1, 0, 0, 0, '0, '0, '0, 3'b000);
        mm[1][8] = 32'h1234_5678;
        access(1, 0, 32'h20, 32'h0, 4'hF, "rd_b2b");

        access(3, 1, 32'h10, 32'hCAFE_F00D, 4'hF, "wr3");
        access(3, 0, 32'h10, 32'h0, 4'hF, "rd3");

        @(posedge clk); #1;
        set_bus(3, 1, 1, 0, 32'h10, '0, 4'hF, 3'b000);
        @(posedge clk); #1;
        set_bus(3, 0, 0, 0, '0, '0, '0, 3'b000);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_noack", get_ack(3), 0);
            chk("abort_noerr", get_err(3), 0);
        end
        access(3, 0, 32'h10, 32'h0, 4'hF, "rd_after_abort");

        @(posedge clk); #1;
        set_bus(3, 1, 1, 0, 32'h10, '0, 4'hF, 3'b000);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack3", get_ack(3), 0);
        chk("midrst_err3", get_err(3), 0);
        chk("midrst_dat3", get_dat(3), 0);
        chk("midrst_dat1", get_dat(1), 0);
        set_bus(3, 0, 0, 0, '0, '0, '0, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last[1] = '0; last[3] = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("postrst_noack", get_ack(3), 0);
        end
        access(3, 0, 32'h10, 32'h0, 4'hF, "rd_after_rst");

        // Prefill a pool of words (0..15, 190..199) so random reads never hit unwritten RAM.
        for (int i = 0; i < 26; i++) begin
            p = (i < 16) ? i : 174 + i;
            access(1, 1, 32'(p) << 2, $urandom, 4'hF, "fill1");
            access(3, 1, 32'(p) << 2, $urandom, 4'hF, "fill3");
        end
        for (int i = 0; i < 80; i++) begin
            r = $urandom % 10;
            p = $urandom % 26;
            p = (p < 16) ? p : 174 + p;
            if (r == 0)      adr = (32'(200 + $urandom % 56) << 2) | 32'($urandom % 4);
            else if (r == 1) adr = 32'h0100_0000 | (32'(p) << 2);
            else             adr = (32'(p) << 2) | 32'($urandom % 4);
            access(($urandom % 2) ? 1 : 3, 1'($urandom % 2), adr, $urandom, 4'($urandom % 16), "rand");
        end

`ifdef WB_SRAM_CTRL_BURST_EN
        begin
            int   beat, acks;
            logic prev;
            for (int i = 0; i < 4; i++) access(2, 1, 32'(i) << 2, 32'(i + 1), 4'hF, "bfill");
            @(posedge clk); #1;
            set_bus(2, 1, 1, 0, 32'h0, '0, 4'hF, 3'b010);
            beat = 0; acks = 0; prev = 1'b0;
            for (int n = 1; n <= 10; n++) begin
                @(posedge clk); #1;
                if (prev && beat < 4) begin
                    beat++;
                    if (beat < 4) set_bus(2, 1, 1, 0, 32'(beat) << 2, '0, 4'hF, (beat == 3) ? 3'b111 : 3'b010);
                    else          set_bus(2, 0, 0, 0, '0, '0, '0, 3'b000);
                end
                prev = get_ack(2);
                chk("burst_noerr", get_err(2), 0);
                if (prev) begin
                    acks++;
                    chk("burst_pos", n, acks + 1);
                    chk("burst_dat", get_dat(2), acks);
                end
            end
            chk("burst_acks", acks, 4);
            last[2] = 32'd4;
            access(2, 0, 32'h8, 32'h0, 4'hF, "rd_after_burst");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
